// File: rtl/bch_enc_arbiter_if.sv
// Requester, status and encoder-side signals of bch_enc_arbiter.
// slave is the arbiter's view; master is the view of the sources and the encoder.
interface bch_enc_arbiter_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned BITS = 8
);
    localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]      req;
    logic [N*BITS-1:0] src_data;
    logic [N-1:0]      src_valid;
    logic [N-1:0]      src_take;
    logic [N-1:0]      grant;
    logic [OW-1:0]     owner;
    logic              busy;
    logic [N-1:0]      done;
    logic [BITS-1:0]   enc_data;
    logic              enc_start;
    logic              enc_ce;
    logic              enc_ready;
    logic              enc_last;

    modport slave (
        input  req, src_data, src_valid, enc_ready, enc_last,
        output src_take, grant, owner, busy, done, enc_data, enc_start, enc_ce
    );

    modport master (
        output req, src_data, src_valid, enc_ready, enc_last,
        input  src_take, grant, owner, busy, done, enc_data, enc_start, enc_ce
    );
endinterface

// File: rtl/bch_enc_arbiter.sv
// Round-robin scheduler sharing one BCH encoder among N beat-streaming requesters.
// Define BCH_ARB_WATCHDOG_EN to add the enc_last timeout and the err_timeout output.
module bch_enc_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned DATA_BITS = 192,
    parameter int unsigned BITS      = 8,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             reset,
    bch_enc_arbiter_if.slave bus
`ifdef BCH_ARB_WATCHDOG_EN
    ,
    output logic             err_timeout
`endif
);
    localparam int unsigned WORDS = (DATA_BITS + BITS - 1) / BITS;
    localparam int unsigned CW    = $clog2(WORDS + 1);
    localparam int unsigned OW    = (N > 1) ? $clog2(N) : 1;

    if (N < 2 || N > 16 || TIMEOUT < 2) begin : g_param_check
        $error("bch_enc_arbiter: N must be 2..16 and TIMEOUT at least 2");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FEED      = 2'd1,
        WAIT_LAST = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  grant_q, grant_n;
    logic [N-1:0]  done_q, done_n;
    logic [OW-1:0] owner_q, owner_n;
    logic [OW-1:0] ptr_q, ptr_n;
    logic          busy_q, busy_n;
    logic [CW-1:0] beat_q, beat_n;
    logic [OW-1:0] sel, cand;
    logic          sel_found;
    logic          take;

`ifdef BCH_ARB_WATCHDOG_EN
    localparam int unsigned TW = $clog2(TIMEOUT);
    logic [TW-1:0] tmr_q, tmr_n;
    logic          err_q, err_n;
    assign err_timeout = err_q;
`endif

    assign bus.grant = grant_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    // First pending request strictly after the pointer, wrapping modulo N.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = OW'((32'(ptr_q) + i) % N);
            if (!sel_found && bus.req[cand]) begin
                sel       = cand;
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n       = state;
        grant_n       = grant_q;
        owner_n       = owner_q;
        ptr_n         = ptr_q;
        busy_n        = busy_q;
        beat_n        = beat_q;
        done_n        = '0;
        bus.src_take  = '0;
        bus.enc_ce    = 1'b0;
        bus.enc_start = 1'b0;
        bus.enc_data  = bus.src_data[32'(owner_q) * BITS +: BITS];
`ifdef BCH_ARB_WATCHDOG_EN
        tmr_n         = tmr_q;
        err_n         = 1'b0;
`endif
        // The first beat also needs the encoder ready; later beats only need data.
        take = (state == FEED) && bus.src_valid[owner_q] && ((beat_q != '0) || bus.enc_ready);

        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_n = N'(1) << sel;
                    owner_n = sel;
                    busy_n  = 1'b1;
                    state_n = FEED;
                end
            end
            FEED: begin
                if (take) begin
                    bus.src_take[owner_q] = 1'b1;
                    bus.enc_ce            = 1'b1;
                    bus.enc_start         = (beat_q == '0);
                    beat_n                = beat_q + CW'(1);
                    if (beat_q == CW'(WORDS - 1)) begin
                        state_n = WAIT_LAST;
`ifdef BCH_ARB_WATCHDOG_EN
                        tmr_n   = '0;
`endif
                    end
                end
            end
            WAIT_LAST: begin
                bus.enc_ce = 1'b1;
                if (bus.enc_last) begin
                    done_n[owner_q] = 1'b1;
                    grant_n         = '0;
                    ptr_n           = owner_q;
                    beat_n          = '0;
                    busy_n          = 1'b0;
                    state_n         = IDLE;
                end
`ifdef BCH_ARB_WATCHDOG_EN
                else if (tmr_q == TW'(TIMEOUT - 2)) begin
                    // Abandon the codeword: pulse the error, release without done.
                    err_n   = 1'b1;
                    grant_n = '0;
                    ptr_n   = owner_q;
                    beat_n  = '0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr_q + TW'(1);
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            owner_q <= '0;
            ptr_q   <= OW'(N - 1);
            busy_q  <= 1'b0;
            beat_q  <= '0;
`ifdef BCH_ARB_WATCHDOG_EN
            tmr_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            done_q  <= done_n;
            owner_q <= owner_n;
            ptr_q   <= ptr_n;
            busy_q  <= busy_n;
            beat_q  <= beat_n;
`ifdef BCH_ARB_WATCHDOG_EN
            tmr_q   <= tmr_n;
            err_q   <= err_n;
`endif
        end
    end
endmodule

// File: tb/tb_bch_enc_arbiter.sv
// Scoreboard bench for bch_enc_arbiter with behavioural requesters and encoder.
// Codeword integrity is tracked as an order-sensitive hash of the beats fed to the encoder.
module tb_bch_enc_arbiter;
    localparam int unsigned N         = 4;
    localparam int unsigned DATA_BITS = 192;
    localparam int unsigned BITS      = 8;
    localparam int unsigned TIMEOUT   = 64;
    localparam int unsigned WORDS     = 24;
    localparam int unsigned ECC       = 4;

    typedef struct {
        int          r;
        logic [31:0] h;
        int          b;
    } exp_t;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic ready_en  = 1'b1;
    logic kill_last = 1'b0;
    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;

    always #5 clk = ~clk;

    bch_enc_arbiter_if #(.N(N), .BITS(BITS)) bus ();

`ifdef BCH_ARB_WATCHDOG_EN
    logic err_timeout;
`endif

    bch_enc_arbiter #(
        .N(N), .DATA_BITS(DATA_BITS), .BITS(BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef BCH_ARB_WATCHDOG_EN
        ,
        .err_timeout(err_timeout)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] hstep(input logic [31:0] h, input logic [BITS-1:0] d);
        return {h[26:0], h[31:27]} ^ 32'(d);
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        int r = 0;
        for (int i = 0; i < int'(N); i++) if (v[i]) r = i;
        return r;
    endfunction

    logic [BITS-1:0] mem [N][WORDS];

    function automatic logic [31:0] exp_hash(input int r);
        logic [31:0] h = '0;
        for (int k = 0; k < int'(WORDS); k++) h = hstep(h, mem[r][k]);
        return h;
    endfunction

    // Requesters: stream their word from idx, optional gap before beat gap_at.
    int idx [N];
    int gap_req = -1;
    int gap_at  = 0;
    int gap_len = 0;
    int gap_cnt = 0;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            bus.src_valid[i] = (idx[i] < int'(WORDS)) &&
                               !(i == gap_req && idx[i] == gap_at && gap_cnt < gap_len);
            bus.src_data[i*BITS +: BITS] = (idx[i] < int'(WORDS)) ? mem[i][idx[i]] : '0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < int'(N); i++) begin
            if (reset || bus.done[i]
`ifdef BCH_ARB_WATCHDOG_EN
                || (err_timeout && idx[i] == int'(WORDS))
`endif
               ) idx[i] <= 0;
            else if (bus.src_take[i]) idx[i] <= idx[i] + 1;
        end
        if (reset || gap_req < 0) gap_cnt <= 0;
        else if (idx[gap_req] != gap_at) gap_cnt <= 0;
        else if (bus.grant[gap_req] && gap_cnt < gap_len) gap_cnt <= gap_cnt + 1;
    end

    // Encoder: hashes WORDS data beats, then streams ECC beats and flags the last one.
    int          ecnt = 0;
    logic [31:0] eh   = '0;

    always @(posedge clk) begin
        if (bus.enc_ce) begin
            if (bus.enc_start) begin
                ecnt <= 1;
                eh   <= hstep(32'h0, bus.enc_data);
            end else begin
                ecnt <= ecnt + 1;
                if (ecnt < int'(WORDS)) eh <= hstep(eh, bus.enc_data);
            end
        end
    end

    assign bus.enc_last  = bus.enc_ce && (ecnt == int'(WORDS + ECC - 1)) && !kill_last;
    assign bus.enc_ready = ready_en;

    // Monitor and scoreboard, sampled on the falling edge.
    exp_t sbq [$];
    exp_t e;
    int   gq [$];
    int   gcq [$];
    int   dcq [$];
    int   takes = 0, starts = 0, bubbles = 0, done_count = 0, last_take_cyc = 0;
    logic first_start = 1'b0;
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] prev_done  = '0;

    always @(negedge clk) begin
        if (bus.grant != '0 && prev_grant == '0) begin
            gq.push_back(oh2i(bus.grant));
            gcq.push_back(cyc);
            takes = 0; starts = 0; bubbles = 0; first_start = 1'b0;
        end
        if (bus.src_take != '0) begin
            if (takes == 0) first_start = bus.enc_start;
            takes++;
            last_take_cyc = cyc;
        end
        if (bus.enc_start) starts++;
        if (bus.busy && !bus.enc_ce) bubbles++;
        check_eq("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        check_eq("take_onehot0", 32'($onehot0(bus.src_take)), 32'd1);
        if (prev_done != '0) check_eq("done_width", 32'(bus.done), 32'd0);
        if (bus.done != '0) begin
            dcq.push_back(cyc);
            done_count++;
            if (sbq.size() == 0) check_eq("done_unexpected", 32'(bus.done), 32'd0);
            else begin
                e = sbq.pop_front();
                check_eq("done_owner", 32'(bus.done), 32'd1 << e.r);
                check_eq("take_count", 32'(takes), 32'(WORDS));
                check_eq("start_count", 32'(starts), 32'd1);
                check_eq("start_first", 32'(first_start), 32'd1);
                check_eq("enc_hash", eh, e.h);
                check_eq("ce_bubbles", 32'(bubbles), 32'(e.b));
            end
        end
        prev_grant = bus.grant;
        prev_done  = bus.done;
    end

    task automatic wait_grant(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.grant == '0 && n < budget);
        check_eq("grant_seen", 32'(bus.grant != '0), 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", 32'(done_count), 32'(target));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check_eq({tag, "_take"}, 32'(bus.src_take), 32'd0);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_start"}, 32'(bus.enc_start), 32'd0);
        check_eq({tag, "_ce"}, 32'(bus.enc_ce), 32'd0);
        check_eq({tag, "_owner"}, 32'(bus.owner), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [DATA_BITS-1:0] w0;
        int g0, d0, dc;
        w0 = 192'h123456789ABCDEF0123456789ABCDEF0123456789ABCDEF1;
        for (int i = 0; i < int'(N); i++)
            for (int k = 0; k < int'(WORDS); k++)
                mem[i][k] = w0[k*BITS +: BITS] + BITS'(i * 37);
        bus.req = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values("rst");

        // Single requester 0, gap-free
        sbq.push_back('{0, exp_hash(0), 0});
        @(posedge clk); #1 bus.req = 4'b0001;
        wait_grant(10);
        check_eq("t1_grant", 32'(bus.grant), 32'h1);
        check_eq("t1_busy", 32'(bus.busy), 32'd1);
        check_eq("t1_start", 32'(bus.enc_start), 32'd1);
        check_eq("t1_take", 32'(bus.src_take), 32'h1);
        @(posedge clk); #1 bus.req = '0;
        wait_done(1, 100);

        // All four requesting: order 0,1,2,3,0 from reset
        pulse_reset();
        g0 = gq.size();
        d0 = dcq.size();
        dc = done_count;
        for (int k = 0; k < 5; k++) sbq.push_back('{k % 4, exp_hash(k % 4), 0});
        bus.req = 4'b1111;
        for (int n = 0; n < 400 && gq.size() < g0 + 5; n++) @(negedge clk);
        @(posedge clk); #1 bus.req = '0;
        wait_done(dc + 5, 200);
        check_eq("rr_grant_count", 32'(gq.size() - g0), 32'd5);
        if (gq.size() >= g0 + 5 && dcq.size() >= d0 + 5) begin
            for (int k = 0; k < 5; k++) check_eq("rr_order", 32'(gq[g0+k]), 32'(k % 4));
            for (int k = 0; k < 4; k++) check_eq("rr_done_to_grant", 32'(gcq[g0+k+1] - dcq[d0+k]), 32'd1);
        end

        // Requester 1 with a 3-cycle source gap after beat 10
        gap_req = 1; gap_at = 11; gap_len = 3;
        sbq.push_back('{1, exp_hash(1), 3});
        dc = done_count;
        @(posedge clk); #1 bus.req = 4'b0010;
        wait_grant(10);
        check_eq("gap_grant", 32'(bus.grant), 32'h2);
        @(posedge clk); #1 bus.req = '0;
        wait_done(dc + 1, 100);
        gap_req = -1; gap_len = 0;

        // Encoder not ready for the first 5 granted cycles
        ready_en = 1'b0;
        sbq.push_back('{0, exp_hash(0), 5});
        dc = done_count;
        @(posedge clk); #1 bus.req = 4'b0001;
        wait_grant(10);
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            check_eq("stall_take", 32'(bus.src_take), 32'd0);
            check_eq("stall_start", 32'(bus.enc_start), 32'd0);
        end
        @(posedge clk); #1 ready_en = 1'b1; bus.req = '0;
        @(negedge clk);
        check_eq("stall_first_take", 32'(bus.src_take), 32'h1);
        check_eq("stall_first_start", 32'(bus.enc_start), 32'd1);
        wait_done(dc + 1, 100);

        // Reset while feeding beat 7 of requester 2, then 0 must win first
        @(posedge clk); #1 bus.req = 4'b0100;
        wait_grant(10);
        check_eq("mid_grant", 32'(bus.grant), 32'h4);
        for (int n = 0; n < 50 && idx[2] != 7; n++) @(negedge clk);
        check_eq("mid_beat", 32'(idx[2]), 32'd7);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values("mid_rst");
        g0 = gq.size();
        dc = done_count;
        sbq.push_back('{0, exp_hash(0), 0});
        sbq.push_back('{2, exp_hash(2), 0});
        bus.req = 4'b0101;
        for (int n = 0; n < 200 && gq.size() < g0 + 2; n++) @(negedge clk);
        @(posedge clk); #1 bus.req = '0;
        wait_done(dc + 2, 100);
        if (gq.size() >= g0 + 2) begin
            check_eq("post_rst_first", 32'(gq[g0]), 32'd0);
            check_eq("post_rst_second", 32'(gq[g0+1]), 32'd2);
        end

`ifdef BCH_ARB_WATCHDOG_EN
        // enc_last never arrives: watchdog releases without done
        kill_last = 1'b1;
        dc = done_count;
        @(posedge clk); #1 bus.req = 4'b0001;
        wait_grant(10);
        @(posedge clk); #1 bus.req = '0;
        for (int n = 0; n < 300 && err_timeout !== 1'b1; n++) @(negedge clk);
        check_eq("wd_err", 32'(err_timeout), 32'd1);
        check_eq("wd_latency", 32'(cyc - last_take_cyc), 32'(TIMEOUT));
        @(negedge clk);
        check_eq("wd_busy", 32'(bus.busy), 32'd0);
        check_eq("wd_err_pulse", 32'(err_timeout), 32'd0);
        repeat (5) @(negedge clk);
        check_eq("wd_no_done", 32'(done_count), 32'(dc));
        kill_last = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bch_enc_arbiter.md
Name: bch_enc_arbiter

Overview:
- Round-robin scheduler that shares one xilinx_encode instance (PIPELINE_STAGES=0) among N requesters. Each requester supplies one codeword of DATA_BITS as BITS-wide beats.
- Sits between the per-sector data sources of the NAND page path and the encoder.
- Sequences the encoder's start, ce and beat mux, and returns a per-requester completion pulse.
- Tags encoder output with the owning requester index.

Parameters:
- N, 4, number of requesters (2..16)
- DATA_BITS, 192, data bits per codeword; must match the encoder
- BITS, 8, beat width; must match the encoder
- TIMEOUT, 64, cycles allowed from the last data beat to enc_last (watchdog only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  N  request per requester; level, sampled in IDLE only
- src_data  in  N*BITS  beat from each requester; requester i occupies [i*BITS +: BITS]
- src_valid  in  N  beat valid per requester
- src_take  out  N  one-hot; beat of granted requester consumed this cycle
- grant  out  N  one-hot registered grant; 0 when idle
- owner  out  $clog2(N)  index of current or last granted requester
- busy  out  1  high in any state except IDLE
- done  out  N  one-cycle pulse to the owner after the encoder's last beat
- enc_data  out  BITS  to encoder data_in
- enc_start  out  1  to encoder start
- enc_ce  out  1  to encoder ce
- enc_ready  in  1  from encoder ready
- enc_last  in  1  from encoder last

Behaviour:
- WORDS = ceil(DATA_BITS/BITS); 24 with the defaults. beat_cnt is $clog2(WORDS+1) bits wide.
- Reset values: grant=0, src_take=0, done=0, busy=0, enc_start=0, enc_ce=0, owner=0, beat_cnt=0, state=IDLE. The round-robin pointer resets to N-1, so requester 0 wins first.
- Reset mid-codeword: all values above are restored next cycle. The encoder is left stalled (enc_ce=0). The next enc_start re-initialises it. No done pulse is issued.
- IDLE:
  - If req is nonzero, select the first set bit searching upward from pointer+1, modulo N.
  - Next cycle: grant, owner and busy update, and the state moves to FEED.
  - With several requests pending, the arbiter starts a new grant on the cycle after done.
- FEED:
  - enc_data = src_data slice of owner (combinational mux).
  - Beat taken when `src_valid[owner] && (beat_cnt!=0 || enc_ready)`.
  - On a taken beat: src_take[owner]=1, enc_ce=1, beat_cnt increments.
  - enc_start=1 only on the taken beat with beat_cnt==0.
  - Not taken: enc_ce=0, which stalls the encoder. Bubbles are allowed anywhere in the codeword.
  - After beat WORDS-1 is taken, go to WAIT_LAST.
  - enc_last seen in FEED is ignored.
- WAIT_LAST:
  - enc_ce=1 so the encoder streams out ECC. src_take=0.
  - On enc_last: done[owner] pulses next cycle, grant clears, pointer=owner, beat_cnt=0, state=IDLE.
  - owner holds its value until the next grant.
- Changes to req after grant are ignored. A granted requester must complete its codeword.
- At most one bit of grant and one bit of src_take may be set; the bench asserts this.

Optional Feature:
- BCH_ARB_WATCHDOG_EN defined:
  - Adds a timeout counter, cleared on entry to WAIT_LAST.
  - If TIMEOUT cycles elapse without enc_last, pulse err_timeout (extra 1-bit output, reset 0) for one cycle.
  - Then clear grant, state=IDLE, pointer=owner, and suppress done.
- Undefined: no err_timeout port, no counter, and WAIT_LAST waits indefinitely.

Test Plan:
- Single req[0] with the 192-bit word 0x123456789ABCDEF0123456789ABCDEF0123456789ABCDEF1 streamed without gaps -> exactly 24 src_take pulses and enc_start on the first only. Encoder data/ecc output matches a standalone encoder run. done=4'b0001 for one cycle.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0. No grant overlap. Each done precedes the next grant by 1 cycle.
- src_valid[owner] dropped for 3 cycles mid-codeword (after beat 10) -> enc_ce=0 for exactly those cycles. Encoded output is identical to the gap-free case.
- enc_ready held low at grant for 5 cycles -> no src_take and no enc_start until enc_ready=1, then the first beat is taken with enc_start=1.
- reset asserted in FEED at beat 7 -> next cycle all outputs at reset values. The next codeword encodes correctly, and req[0] is granted first.
- With BCH_ARB_WATCHDOG_EN and enc_last forced low -> err_timeout pulses TIMEOUT=64 cycles after the last data beat. No done pulse. busy=0 next cycle.
